// File: rtl/pipe_ctrl_pkg.sv
// Shared types and opcode constants for the pipeline sequencer.
package pipe_ctrl_pkg;

  // RV32I major opcodes the sequencer and its neighbours care about
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_ADDI  = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_CHECK,
    S_MEM,
    S_FLUSH,
    S_ERR
  } state_t;

  // True for the opcodes that need a data-memory access
  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_wait_timer.sv
// Saturating wait counter; expired is high while the count sits at LIMIT.
module wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic arstn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // Clear wins over counting; the count holds once it reaches LIMIT
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT_V)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT_V);

endmodule

// File: rtl/pipeline_sequencer.sv
// Central sequencer for the two-stage pipeline: fetch handshake, data-memory
// freeze, jal flush and handshake timeout supervision.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            arstn,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_out,
  output logic            instr_valid,
  input  logic [6:0]      ex_opcode,
  input  logic            jump_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            pipe_en,
  output logic            pc_en,
  output logic            flush,
  output logic            timeout_err
);

  state_t state;
  state_t next_state;

  // active stays low until the first edge after reset, so requests are
  // held off while arstn is asserted even though state already reads S_FETCH
  logic active;
  logic mem_is_store;
  logic timer_clear;
  logic timer_count_en;
  logic timer_expired;

  wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk      (clk),
    .arstn    (arstn),
    .clear    (timer_clear),
    .count_en (timer_count_en),
    .expired  (timer_expired)
  );

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; an ack arriving with the timer expired still wins
  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH: begin
        if (active) begin
          if (imem_ack) begin
            next_state = S_CHECK;
          end else if (timer_expired) begin
            next_state = S_ERR;
          end
        end
      end
      S_CHECK: begin
        if (jump_taken) begin
          next_state = S_FLUSH;
        end else if (is_mem_op(ex_opcode)) begin
          next_state = S_MEM;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          next_state = S_FETCH;
        end else if (timer_expired) begin
          next_state = S_ERR;
        end
      end
      S_FLUSH: next_state = S_FETCH;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_FETCH;
    endcase
  end

  // Output decode: Moore on state, except the advance strobe follows imem_ack
  always_comb begin
    imem_req       = active && (state == S_FETCH);
    pipe_en        = imem_req && imem_ack;
    pc_en          = pipe_en;
    dmem_req       = (state == S_MEM);
    dmem_we        = dmem_req && mem_is_store;
    flush          = (state == S_FLUSH);
    timer_clear    = (next_state != state);
    timer_count_en = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
  end

  // Instruction register, store latch, sticky error and start-up qualifier
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      active       <= 1'b0;
      instr_out    <= '0;
      instr_valid  <= 1'b0;
      mem_is_store <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (pipe_en) begin
        instr_out   <= imem_rdata;
        instr_valid <= 1'b1;
      end else if (state == S_FLUSH) begin
        instr_valid <= 1'b0;
      end
      if (state == S_CHECK) begin
        mem_is_store <= (ex_opcode == OPC_STORE);
      end
      if (next_state == S_ERR) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
